// File: rtl/uart_monitor_pkg.sv
// Shared types and constants for the uart_monitor bench-side UART endpoint.
package uart_monitor_pkg;
   localparam int OVERSAMPLE   = 16;
   localparam int SAMPLE_PHASE = 8;

   typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD} parity_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;
endpackage

// File: rtl/uart_monitor_fifo.sv
// Generic first-word-fall-through FIFO; head holds the last popped word while empty.
module uart_monitor_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             wdata,
   output logic [WIDTH-1:0]             rdata,
   output logic                         full,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [LW-1:0]    count;
   logic [WIDTH-1:0] last_q;
   logic             do_push, do_pop;

   assign full    = (count == LW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = empty ? last_q : mem[rd_ptr];
   assign level   = count;

   // NOTE: the storage array has no reset; only pointers, count and the hold register do,
   // and rdata never exposes the array while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         last_q <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            last_q <= mem[rd_ptr];
         end
         count <= count + LW'(do_push) - LW'(do_pop);
      end
   end
endmodule

// File: rtl/uart_monitor.sv
// Bench-side UART endpoint: runtime tick generator, oversampling RX with FIFO and
// error/break reporting, and a handshake-driven TX for stimulus injection.
module uart_monitor
   import uart_monitor_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_W      = 16
) (
   input  logic                            sys_clk_i,
   input  logic                            sys_rst_ni,
   input  logic [DIV_W-1:0]                divisor_i,
   input  logic                            uart_rx_i,
   output logic                            uart_tx_o,
   output logic [DATA_BITS-1:0]            rx_data_o,
   output logic                            rx_valid_o,
   input  logic                            rx_ready_i,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_level_o,
   output logic                            frame_err_o,
   output logic                            parity_err_o,
   output logic                            break_o,
   output logic                            overflow_o,
   input  logic                            ovf_clr_i,
   input  logic [DATA_BITS-1:0]            tx_data_i,
   input  logic                            tx_valid_i,
   output logic                            tx_ready_o
);
   localparam parity_e PAR_MODE = parity_e'(PARITY);

   logic [DIV_W-1:0] tick_cnt;
   logic             run, tick;

   assign run  = (divisor_i != '0);
   assign tick = run && (tick_cnt == '0);

   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni)            tick_cnt <= '0;
      else if (!run)              tick_cnt <= '0;
      else if (tick_cnt == '0)    tick_cnt <= divisor_i - 1'b1;
      else                        tick_cnt <= tick_cnt - 1'b1;
   end

   // Synchroniser and edge history reset to the idle (high) line level.
   logic rx_meta, rx_sync, rx_prev;
   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= uart_rx_i;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   rx_state_e            rx_state;
   logic [3:0]           rx_phase, rx_idx;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_par_acc, rx_any_high, rx_stop_err;
   logic                 push, fifo_full, fifo_empty, pop;
   logic                 rx_bit_end, stop_err_n, any_high_n, rx_par_bad;

   assign rx_bit_end = tick && (rx_phase == 4'(OVERSAMPLE-1));
   assign stop_err_n = rx_stop_err | ~rx_sync;
   assign any_high_n = rx_any_high | rx_sync;
   assign rx_par_bad = (PAR_MODE == PAR_EVEN) ? rx_par_acc :
                       (PAR_MODE == PAR_ODD)  ? ~rx_par_acc : 1'b0;

   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
         rx_state     <= RX_IDLE;
         rx_phase     <= '0;
         rx_idx       <= '0;
         rx_shift     <= '0;
         rx_par_acc   <= 1'b0;
         rx_any_high  <= 1'b0;
         rx_stop_err  <= 1'b0;
         push         <= 1'b0;
         frame_err_o  <= 1'b0;
         parity_err_o <= 1'b0;
         break_o      <= 1'b0;
      end else begin
         push         <= 1'b0;
         frame_err_o  <= 1'b0;
         parity_err_o <= 1'b0;
         break_o      <= 1'b0;
         if (tick) rx_phase <= rx_phase + 1'b1;
         case (rx_state)
            RX_IDLE: if (run && rx_prev && !rx_sync) begin
               rx_state <= RX_START;
               rx_phase <= '0;
            end
            RX_START: if (tick && rx_phase == 4'(SAMPLE_PHASE-1)) begin
               rx_phase <= '0;
               if (rx_sync) rx_state <= RX_IDLE;
               else begin
                  rx_state    <= RX_DATA;
                  rx_idx      <= '0;
                  rx_par_acc  <= 1'b0;
                  rx_any_high <= 1'b0;
                  rx_stop_err <= 1'b0;
               end
            end
            RX_DATA: if (rx_bit_end) begin
               rx_shift    <= {rx_sync, rx_shift[DATA_BITS-1:1]};
               rx_par_acc  <= rx_par_acc ^ rx_sync;
               rx_any_high <= any_high_n;
               if (rx_idx == 4'(DATA_BITS-1)) begin
                  rx_idx   <= '0;
                  rx_state <= (PAR_MODE == PAR_NONE) ? RX_STOP : RX_PAR;
               end else rx_idx <= rx_idx + 1'b1;
            end
            RX_PAR: if (rx_bit_end) begin
               rx_par_acc  <= rx_par_acc ^ rx_sync;
               rx_any_high <= any_high_n;
               rx_state    <= RX_STOP;
            end
            RX_STOP: if (rx_bit_end) begin
               if (rx_idx == 4'(STOP_BITS-1)) begin
                  rx_state <= RX_IDLE;
                  if (!any_high_n) break_o <= 1'b1;
                  else if (stop_err_n || rx_par_bad) begin
                     frame_err_o  <= stop_err_n;
                     parity_err_o <= rx_par_bad;
                  end else push <= 1'b1;
               end else begin
                  rx_idx      <= rx_idx + 1'b1;
                  rx_stop_err <= stop_err_n;
                  rx_any_high <= any_high_n;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   assign rx_valid_o = ~fifo_empty;
   assign pop        = rx_valid_o & rx_ready_i;

   uart_monitor_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (sys_clk_i),
      .rst_n (sys_rst_ni),
      .push  (push),
      .pop   (pop),
      .wdata (rx_shift),
      .rdata (rx_data_o),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (rx_level_o)
   );

   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) overflow_o <= 1'b0;
      else             overflow_o <= (push & fifo_full & ~pop) | (overflow_o & ~ovf_clr_i);
   end

   tx_state_e            tx_state;
   logic [3:0]           tx_phase, tx_idx;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_par, tx_started, tx_b2b, tx_bit_end;

   assign tx_bit_end = tick && (tx_phase == 4'(OVERSAMPLE-1));

   always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
      if (!sys_rst_ni) begin
         tx_state   <= TX_IDLE;
         tx_phase   <= '0;
         tx_idx     <= '0;
         tx_shift   <= '0;
         tx_par     <= 1'b0;
         tx_started <= 1'b0;
         tx_b2b     <= 1'b0;
         uart_tx_o  <= 1'b1;
         tx_ready_o <= 1'b1;
      end else begin
         tx_b2b <= 1'b0;
         if (tick) tx_phase <= tx_phase + 1'b1;
         case (tx_state)
            TX_IDLE: if (tx_valid_i && tx_ready_o) begin
               tx_shift   <= tx_data_i;
               tx_par     <= (^tx_data_i) ^ (PAR_MODE == PAR_ODD);
               tx_ready_o <= 1'b0;
               tx_state   <= TX_START;
               // Accepting right after a stop bit ended: that tick boundary is now, start at once.
               tx_started <= tx_b2b;
               if (tx_b2b) uart_tx_o <= 1'b0;
            end
            TX_START: if (!tx_started) begin
               if (tick) begin
                  uart_tx_o  <= 1'b0;
                  tx_started <= 1'b1;
                  tx_phase   <= '0;
               end
            end else if (tx_bit_end) begin
               uart_tx_o <= tx_shift[0];
               tx_shift  <= tx_shift >> 1;
               tx_idx    <= '0;
               tx_state  <= TX_DATA;
            end
            TX_DATA: if (tx_bit_end) begin
               if (tx_idx == 4'(DATA_BITS-1)) begin
                  tx_idx <= '0;
                  if (PAR_MODE == PAR_NONE) begin
                     uart_tx_o <= 1'b1;
                     tx_state  <= TX_STOP;
                  end else begin
                     uart_tx_o <= tx_par;
                     tx_state  <= TX_PAR;
                  end
               end else begin
                  uart_tx_o <= tx_shift[0];
                  tx_shift  <= tx_shift >> 1;
                  tx_idx    <= tx_idx + 1'b1;
               end
            end
            TX_PAR: if (tx_bit_end) begin
               uart_tx_o <= 1'b1;
               tx_state  <= TX_STOP;
            end
            TX_STOP: if (tx_bit_end) begin
               if (tx_idx == 4'(STOP_BITS-1)) begin
                  tx_state   <= TX_IDLE;
                  tx_ready_o <= 1'b1;
                  tx_b2b     <= 1'b1;
               end else tx_idx <= tx_idx + 1'b1;
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_monitor.sv
// Scoreboard bench for uart_monitor: an 8N1 instance (loopback-capable) and an 8E1 instance.
module tb_uart_monitor;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] div;

   logic       drv_a, loop_a, line_a, tx_a, valid_a, ready_a, ferr_a, perr_a, brk_a, ovf_a, clr_a;
   logic       txv_a, txr_a;
   logic [7:0] data_a, txd_a;
   logic [2:0] level_a;

   logic       drv_p, tx_p, valid_p, ready_p, ferr_p, perr_p, brk_p, ovf_p, txr_p;
   logic [7:0] data_p;
   logic [2:0] level_p;

   int n_tests = 0, n_fail = 0;
   int n_ferr_a = 0, n_perr_a = 0, n_brk_a = 0, n_ferr_p = 0, n_perr_p = 0;
   logic [7:0] exp_a[$], exp_p[$];

   always #5 clk = ~clk;
   assign line_a = loop_a ? tx_a : drv_a;

   uart_monitor #(.FIFO_DEPTH(4)) dut_a (
      .sys_clk_i(clk), .sys_rst_ni(rst_n), .divisor_i(div), .uart_rx_i(line_a),
      .uart_tx_o(tx_a), .rx_data_o(data_a), .rx_valid_o(valid_a), .rx_ready_i(ready_a),
      .rx_level_o(level_a), .frame_err_o(ferr_a), .parity_err_o(perr_a), .break_o(brk_a),
      .overflow_o(ovf_a), .ovf_clr_i(clr_a), .tx_data_i(txd_a), .tx_valid_i(txv_a),
      .tx_ready_o(txr_a));

   uart_monitor #(.PARITY(1), .FIFO_DEPTH(4)) dut_p (
      .sys_clk_i(clk), .sys_rst_ni(rst_n), .divisor_i(div), .uart_rx_i(drv_p),
      .uart_tx_o(tx_p), .rx_data_o(data_p), .rx_valid_o(valid_p), .rx_ready_i(ready_p),
      .rx_level_o(level_p), .frame_err_o(ferr_p), .parity_err_o(perr_p), .break_o(brk_p),
      .overflow_o(ovf_p), .ovf_clr_i(1'b0), .tx_data_i(8'h00), .tx_valid_i(1'b0),
      .tx_ready_o(txr_p));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Pulse counters and scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (ferr_a) n_ferr_a++;
      if (perr_a) n_perr_a++;
      if (brk_a)  n_brk_a++;
      if (ferr_p) n_ferr_p++;
      if (perr_p) n_perr_p++;
      if (rst_n && valid_a && ready_a) begin
         if (exp_a.size() == 0) check("rx_a_extra_pop", exp_a.size(), 1);
         else check("rx_a_data", data_a, exp_a.pop_front());
      end
      if (rst_n && valid_p && ready_p) begin
         if (exp_p.size() == 0) check("rx_p_extra_pop", exp_p.size(), 1);
         else check("rx_p_data", data_p, exp_p.pop_front());
      end
   end

   task automatic tick_wait(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int which, input logic v);
      if (which == 0) drv_a = v; else drv_p = v;
      tick_wait(16 * int'(div));
   endtask

   task automatic send_frame(input int which, input logic [7:0] d, input logic has_par,
                             input logic par, input logic stop);
      drive_bit(which, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
      if (has_par) drive_bit(which, par);
      drive_bit(which, stop);
      drive_bit(which, 1'b1);
      drive_bit(which, 1'b1);
   endtask

   task automatic tx_send(input logic [7:0] d);
      int c = 0;
      while (txr_a !== 1'b1 && c < 20000) begin tick_wait(1); c++; end
      check("tx_ready_wait", txr_a, 1);
      txd_a = d;
      txv_a = 1'b1;
      tick_wait(1);
      txv_a = 1'b0;
   endtask

   initial begin
      int c, ferr0, brk0;
      rst_n = 1'b0; div = 16'd43;
      drv_a = 1'b1; loop_a = 1'b0; ready_a = 1'b0; clr_a = 1'b0; txd_a = '0; txv_a = 1'b0;
      drv_p = 1'b1; ready_p = 1'b0;
      tick_wait(5);
      check("rst_tx_line", tx_a, 1);
      check("rst_tx_ready", txr_a, 1);
      check("rst_rx_valid", valid_a, 0);
      check("rst_rx_level", level_a, 0);
      check("rst_rx_data", data_a, 0);
      check("rst_pulses", {ferr_a, perr_a, brk_a, ovf_a}, 0);
      rst_n = 1'b1;
      tick_wait(3);

      // 8N1 loopback at divisor 43, with timing of valid and tx_ready
      loop_a = 1'b1;
      txd_a = 8'h41; txv_a = 1'b1;
      tick_wait(1);
      txv_a = 1'b0;
      check("tx_ready_drop", txr_a, 0);
      c = 0;
      while (tx_a !== 1'b0 && c < 200) begin tick_wait(1); c++; end
      check("tx_start_seen", tx_a, 0);
      c = 0;
      while (valid_a !== 1'b1 && c < 8000) begin tick_wait(1); c++; end
      check("valid_latency_in_window", (c >= 6530 && c <= 6545), 1);
      check("lb_data", data_a, 8'h41);
      check("lb_valid", valid_a, 1);
      check("lb_level", level_a, 1);
      while (txr_a !== 1'b1 && c < 8000) begin tick_wait(1); c++; end
      check("frame_len_in_window", (c >= 6875 && c <= 6885), 1);
      exp_a.push_back(8'h41);
      ready_a = 1'b1;
      tick_wait(3);
      check("lb_drained", level_a, 0);
      check("lb_sb_empty", exp_a.size(), 0);
      loop_a = 1'b0;

      div = 16'd4;
      tick_wait(200);

      // stop bit low on 0x55
      ferr0 = n_ferr_a;
      send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
      check("ferr_pulse", n_ferr_a - ferr0, 1);
      check("ferr_no_push", level_a, 0);

      // short glitch, then a good frame proves RX is back in IDLE
      drv_a = 1'b0; tick_wait(4); drv_a = 1'b1;
      tick_wait(128);
      check("glitch_no_flags", n_ferr_a + n_perr_a + n_brk_a - ferr0, 1);
      exp_a.push_back(8'h5A);
      send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1);
      check("post_glitch_rx", exp_a.size(), 0);

      // break: 12 bit periods low
      brk0 = n_brk_a; ferr0 = n_ferr_a;
      drv_a = 1'b0;
      tick_wait(12 * 16 * int'(div));
      check("break_pulse", n_brk_a - brk0, 1);
      check("break_no_ferr", n_ferr_a - ferr0, 0);
      check("break_no_push", level_a, 0);
      drv_a = 1'b1;
      tick_wait(128);
      check("break_single", n_brk_a - brk0, 1);

      // overflow with FIFO_DEPTH=4
      ready_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i < 4) exp_a.push_back(8'h10 + 8'(i));
         send_frame(0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
      end
      check("ovf_level", level_a, 4);
      check("ovf_flag", ovf_a, 1);
      ready_a = 1'b1;
      tick_wait(10);
      check("ovf_drained", level_a, 0);
      check("ovf_sb_empty", exp_a.size(), 0);
      check("ovf_sticky", ovf_a, 1);
      clr_a = 1'b1; tick_wait(1); clr_a = 1'b0;
      check("ovf_cleared", ovf_a, 0);

      // even parity instance: 0x03 needs parity bit 0
      send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
      check("perr_pulse", n_perr_p, 1);
      check("perr_no_push", level_p, 0);
      exp_p.push_back(8'h03);
      send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1);
      check("par_ok_level", level_p, 1);
      check("par_ok_no_err", n_perr_p + n_ferr_p, 1);
      ready_p = 1'b1;
      tick_wait(3);
      check("par_sb_empty", exp_p.size(), 0);

      // reset in the middle of a TX frame
      tx_send(8'h00);
      tick_wait(200);
      check("tx_mid_low", tx_a, 0);
      check("tx_mid_busy", txr_a, 0);
      rst_n = 1'b0;
      #1;
      check("rst_mid_tx_line", tx_a, 1);
      check("rst_mid_tx_ready", txr_a, 1);
      tick_wait(3);
      rst_n = 1'b1;
      tick_wait(3);

      // loopback after reset, then a back-to-back frame
      loop_a = 1'b1;
      exp_a.push_back(8'hA5);
      exp_a.push_back(8'h3C);
      tx_send(8'hA5);
      tx_send(8'h3C);
      c = 0;
      while (exp_a.size() != 0 && c < 3000) begin tick_wait(1); c++; end
      check("post_rst_lb_sb_empty", exp_a.size(), 0);
      check("post_rst_no_ferr", n_ferr_a - ferr0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
